// File: rtl/nexys7seg_scroller.sv
// nexys7seg_scroller: Wishbone slave that queues 16-bit display words in a
// FIFO and presents them one at a time on word_o. Each word is held for a
// programmable dwell (in prescaler ticks). When the queue is empty, the last
// word stays on the display.
// Optional feature macro: NEXYS7SEG_SCROLL_RDBACK_EN enables register
// read-back. When it is undefined, wb_dat_o is tied to zero.
module nexys7seg_scroller #(
  parameter int          DEPTH_LOG2 = 3,
  parameter int          PRESCALE   = 1024,
  parameter logic [15:0] DWELL_RST  = 16'd100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [15:0] wb_dat_o,
  output logic [15:0] word_o,
  output logic        busy_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = $clog2(PRESCALE);

  typedef enum logic {ST_IDLE, ST_SHOW} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_ack;
  logic [15:0]           r_dwell;
  logic                  r_hold;
  logic                  r_ovf;
  logic                  r_push_vld;
  logic [15:0]           r_push_dat;
  logic [15:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [15:0]           r_word;
  logic [15:0]           r_dwell_cur;
  logic [15:0]           r_ticks;
  logic [PW-1:0]         r_pre;

  logic w_acc, w_wr, w_clr, w_empty, w_full, w_push, w_pop;
  logic w_tick, w_dwell_done;

  assign w_acc        = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr         = w_acc & wb_we_i & (wb_sel_i == 2'b11);
  assign w_clr        = w_wr & (wb_adr_i == 2'd3) & wb_dat_i[0];
  assign w_empty      = (r_level == '0);
  assign w_full       = (r_level == (DEPTH_LOG2+1)'(DEPTH));
  // A DATA write lands in the FIFO one edge after it is accepted; CLR wins.
  assign w_push       = r_push_vld & ~w_full & ~w_clr;
  assign w_tick       = (r_pre == PW'(PRESCALE - 1));
  assign w_dwell_done = w_tick & ((r_ticks + 16'd1) == r_dwell_cur);

  // Bus handshake and writable control registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack      <= 1'b0;
      r_dwell    <= DWELL_RST;
      r_hold     <= 1'b0;
      r_push_vld <= 1'b0;
      r_push_dat <= 16'h0000;
    end else begin
      r_ack      <= w_acc;
      r_push_vld <= w_wr & (wb_adr_i == 2'd0);
      if (w_wr && wb_adr_i == 2'd0) r_push_dat <= wb_dat_i;
      if (w_wr && wb_adr_i == 2'd1) r_dwell    <= wb_dat_i;
      if (w_wr && wb_adr_i == 2'd3) r_hold     <= wb_dat_i[1];
    end
  end

  // FIFO pointers, fill level and overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      r_level <= r_level + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
      r_ovf   <= r_ovf | (r_push_vld & w_full);
    end
  end

  // FIFO storage.
  // NOTE: the storage array is not reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= r_push_dat;
  end

  // Display FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Display FSM next-state and pop decision.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !r_hold && !w_clr) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!r_hold && w_dwell_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shown word, prescaler and dwell tick counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_word      <= 16'h0000;
      r_pre       <= '0;
      r_ticks     <= 16'h0000;
      r_dwell_cur <= 16'h0000;
    end else if (w_pop) begin
      r_word      <= r_mem[r_rd_ptr];
      r_pre       <= '0;
      r_ticks     <= 16'h0000;
      // Dwell is latched here so a DWELL write only affects the next word.
      r_dwell_cur <= (r_dwell == 16'h0000) ? 16'd1 : r_dwell;
    end else if (r_state == ST_SHOW && !r_hold) begin
      if (w_tick) begin
        r_pre   <= '0;
        r_ticks <= r_ticks + 16'd1;
      end else begin
        r_pre   <= r_pre + PW'(1);
      end
    end
  end

`ifdef NEXYS7SEG_SCROLL_RDBACK_EN
  logic [15:0] r_dat;
  logic [15:0] w_rd_mux;

  // Read-data select from pre-edge register state.
  always_comb begin
    w_rd_mux = 16'h0000;
    case (wb_adr_i)
      2'd0: w_rd_mux = r_word;
      2'd1: w_rd_mux = r_dwell;
      2'd2: w_rd_mux = {11'b0, r_ovf, 4'(r_level), w_full};
      2'd3: w_rd_mux = {14'b0, r_hold, 1'b0};
      default: w_rd_mux = 16'h0000;
    endcase
  end

  // Read data is captured on the accept edge so it is valid alongside ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      r_dat <= 16'h0000;
    else if (w_acc) r_dat <= w_rd_mux;
  end

  assign wb_dat_o = r_dat;
`else
  assign wb_dat_o = 16'h0000;
`endif

  assign wb_ack_o = r_ack;
  assign word_o   = r_word;
  assign busy_o   = (r_state == ST_SHOW) | ~w_empty;

endmodule

// File: tb/tb_nexys7seg_scroller.sv
// Testbench for nexys7seg_scroller: directed bus traffic, a queue-based
// behavioural model compared every cycle, and literal expectations for the
// key timing points (pop latency, dwell length, overflow, CLR, async reset).
`timescale 1ns/1ps
module tb_nexys7seg_scroller;
  localparam int          P    = 4;
  localparam logic [15:0] DRST = 16'd100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  adr;
  logic [15:0] dat_i;
  logic [1:0]  sel;
  logic        we, cyc, stb;
  logic        ack;
  logic [15:0] dat_o;
  logic [15:0] word;
  logic        busy;

  int checks = 0;
  int errors = 0;

  nexys7seg_scroller #(
    .DEPTH_LOG2(3),
    .PRESCALE  (P),
    .DWELL_RST (DRST)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .wb_adr_i(adr),
    .wb_dat_i(dat_i),
    .wb_sel_i(sel),
    .wb_we_i (we),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_ack_o(ack),
    .wb_dat_o(dat_o),
    .word_o  (word),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read-back value: the value itself, or zero without read-back.
  function automatic logic [15:0] rb(input logic [15:0] v);
`ifdef NEXYS7SEG_SCROLL_RDBACK_EN
    return v;
`else
    return v & 16'h0000;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] m_q[$];
  logic [15:0] m_word, m_dwell, m_rdata, m_pdat;
  logic        m_showing, m_hold, m_ovf, m_ack, m_pvld;
  logic        m_acc, m_wr, m_clr;
  int          m_remain;
  int          m_pre_size;

  function automatic logic [15:0] rd_expect(input logic [1:0] a);
    logic [15:0] v;
    int sz;
    sz = m_q.size();
    case (a)
      2'd0:    v = m_word;
      2'd1:    v = m_dwell;
      2'd2:    v = 16'((m_ovf ? 32 : 0) + sz * 2 + (sz == 8 ? 1 : 0));
      default: v = m_hold ? 16'h0002 : 16'h0000;
    endcase
    return rb(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_word = 16'h0000; m_dwell = DRST; m_rdata = 16'h0000; m_pdat = 16'h0000;
      m_showing = 1'b0; m_hold = 1'b0; m_ovf = 1'b0; m_ack = 1'b0; m_pvld = 1'b0;
      m_remain = 0;
    end else begin
      m_acc = cyc & stb & ~m_ack;
      m_wr  = m_acc & we & (sel == 2'b11);
      m_clr = m_wr & (adr == 2'd3) & dat_i[0];
      if (m_acc) m_rdata = rd_expect(adr);
      m_pre_size = m_q.size();
      // A word occupies the display for max(DWELL,1)*P cycles, then one idle cycle.
      if (m_showing) begin
        if (!m_hold) begin
          m_remain--;
          if (m_remain == 0) m_showing = 1'b0;
        end
      end else if (m_pre_size > 0 && !m_hold && !m_clr) begin
        m_word    = m_q.pop_front();
        m_remain  = ((m_dwell == 16'd0) ? 1 : int'(m_dwell)) * P;
        m_showing = 1'b1;
      end
      if (m_clr) begin
        m_q.delete();
        m_ovf = 1'b0;
      end else if (m_pvld) begin
        if (m_pre_size == 8) m_ovf = 1'b1;
        else                 m_q.push_back(m_pdat);
      end
      m_pvld = m_wr & (adr == 2'd0);
      m_pdat = dat_i;
      if (m_wr && adr == 2'd1) m_dwell = dat_i;
      if (m_wr && adr == 2'd3) m_hold  = dat_i[1];
      m_ack = m_acc;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model word_o", word, m_word);
      check("model busy_o", 16'(busy), 16'(m_showing || (m_q.size() > 0)));
      check("model ack", 16'(ack), 16'(m_ack));
      if (ack) check("model rdata", dat_o, m_rdata);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_wr_sel(input logic [1:0] a, input logic [15:0] d, input logic [1:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = s; adr = a; dat_i = d;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 2'b00;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [15:0] d);
    wb_wr_sel(a, d, 2'b11);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 2'b11; adr = a;
    @(negedge clk);
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] rdv;
  int          n;
  logic        seen9;

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_i = 16'h0; sel = 2'b00;
    repeat (3) @(negedge clk);
    check("reset word_o", word, 16'h0000);
    check("reset busy_o", 16'(busy), 16'h0000);
    check("reset ack", 16'(ack), 16'h0000);
    check("reset dat_o", dat_o, 16'h0000);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    wb_read(2'd2, rdv); check("status after reset", rdv, 16'h0000);
    wb_read(2'd1, rdv); check("dwell after reset", rdv, rb(16'd100));

    // Two words, DWELL=2: 9-cycle hold for the first word.
    wb_write(2'd1, 16'd2);
    wb_write(2'd0, 16'h1234);
    check("push pending not busy", 16'(busy), 16'h0000);
    wb_write(2'd0, 16'hABCD);
    check("first word 2 cycles after accept", word, 16'h1234);
    n = 0;
    while (word != 16'hABCD && n < 40) begin @(negedge clk); n++; end
    check("first word hold cycles", 16'(n), 16'd9);
    check("second word shown", word, 16'hABCD);
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    check("busy falls after last dwell", 16'(n), 16'd8);
    check("last word held", word, 16'hABCD);
    wb_read(2'd0, rdv); check("data reads word_o", rdv, rb(16'hABCD));

    // Partial byte select and STATUS writes are ignored.
    wb_wr_sel(2'd1, 16'd5, 2'b01);
    wb_read(2'd1, rdv); check("partial sel ignored", rdv, rb(16'd2));
    wb_write(2'd2, 16'hFFFF);
    wb_read(2'd2, rdv); check("status write ignored", rdv, 16'h0000);

    // HOLD with 9 writes: overflow, full queue, 9th word dropped.
    wb_write(2'd3, 16'h0002);
    for (int i = 0; i < 9; i++) wb_write(2'd0, 16'h1000 + 16'(i));
    check("hold prevents pop", word, 16'hABCD);
    wb_read(2'd2, rdv); check("status full+ovf", rdv, rb(16'h0031));
    wb_read(2'd3, rdv); check("control reads hold", rdv, rb(16'h0002));
    wb_write(2'd3, 16'h0000);
    seen9 = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      if (word == 16'h1008) seen9 = 1'b1;
      n++;
    end
    check("drain completed", 16'(busy), 16'h0000);
    check("9th word never shown", 16'(seen9), 16'h0000);
    check("last queued word", word, 16'h1007);

    // CLR in SHOW with 3 words queued.
    wb_write(2'd1, 16'd4);
    for (int i = 0; i < 4; i++) wb_write(2'd0, 16'h2000 + 16'(i));
    wb_read(2'd2, rdv); check("status 3 queued + ovf", rdv, rb(16'h0026));
    wb_write(2'd3, 16'h0001);
    wb_read(2'd2, rdv); check("status after clr", rdv, 16'h0000);
    wb_read(2'd3, rdv); check("clr self-clears", rdv, 16'h0000);
    check("clr keeps word", word, 16'h2000);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    check("clr dwell ends", 16'(busy), 16'h0000);
    check("no pop after clr", word, 16'h2000);

    // DWELL=0 behaves as 1: 5-cycle hold.
    wb_write(2'd1, 16'd0);
    wb_read(2'd1, rdv); check("dwell zero reads", rdv, rb(16'd0));
    wb_write(2'd0, 16'h3000);
    wb_write(2'd0, 16'h3001);
    check("dwell0 first word", word, 16'h3000);
    n = 0;
    while (word != 16'h3001 && n < 40) begin @(negedge clk); n++; end
    check("dwell0 hold cycles", 16'(n), 16'd5);
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    check("dwell0 busy falls", 16'(busy), 16'h0000);

    // Asynchronous reset in the middle of a dwell.
    wb_write(2'd1, 16'd3);
    wb_write(2'd0, 16'h4000);
    wb_write(2'd0, 16'h4001);
    wb_write(2'd0, 16'h4002);
    repeat (3) @(negedge clk);
    check("showing before reset", word, 16'h4000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst word_o", word, 16'h0000);
    check("async rst busy_o", 16'(busy), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    wb_read(2'd1, rdv); check("dwell after async rst", rdv, rb(16'd100));
    wb_read(2'd2, rdv); check("status after async rst", rdv, 16'h0000);
    check("word after async rst", word, 16'h0000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
